// File: rtl/proj_pkg.sv
// Shared constants for the sorter/extender projection path and the state
// type used by the index streamer.
package proj_pkg;

    localparam int unsigned SORTER_EXTENDER_INDICES_COUNT = 4;
    localparam int unsigned INDICE_LEN                    = 8;
    localparam int unsigned SORTER_POSITION_LEN           = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } streamer_state_t;

endpackage

// File: rtl/proj_index_streamer.sv
// Captures the sorter's parallel smallest-signature indices on a rising
// sort_valid and streams them out one per beat over valid/ready, with a
// last marker on the final beat and a one-cycle done pulse afterwards.
// Optional build macro PROJ_STREAMER_DESCENDING_EN: stream from slot
// INDICES_COUNT-1 down to slot 0 instead of slot 0 upwards.
module proj_index_streamer #(
    parameter int unsigned INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
    parameter int unsigned INDICE_LEN    = proj_pkg::INDICE_LEN,
    parameter int unsigned POSITION_LEN  = proj_pkg::SORTER_POSITION_LEN
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_smallest_idx,
    input  logic                                   sort_valid,
    output logic [INDICE_LEN-1:0]                  out_index,
    output logic [POSITION_LEN-1:0]                out_position,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic                                   out_done,
    output logic                                   busy,
    output logic                                   overrun_err
);

    import proj_pkg::*;

`ifdef PROJ_STREAMER_DESCENDING_EN
    localparam logic [POSITION_LEN-1:0] FIRST_SLOT = POSITION_LEN'(INDICES_COUNT - 1);
    localparam logic [POSITION_LEN-1:0] LAST_SLOT  = '0;
`else
    localparam logic [POSITION_LEN-1:0] FIRST_SLOT = '0;
    localparam logic [POSITION_LEN-1:0] LAST_SLOT  = POSITION_LEN'(INDICES_COUNT - 1);
`endif

    streamer_state_t                         r_state;
    logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] r_buf;
    logic [POSITION_LEN-1:0]                 r_cnt;
    logic [INDICE_LEN-1:0]                   r_out_index;
    logic                                    r_out_valid;
    logic                                    r_out_last;
    logic                                    r_out_done;
    logic                                    r_overrun;
    logic                                    r_sort_valid_d;
    // Set once sort_valid has been seen low after reset, so a level held
    // high across reset release is not mistaken for a fresh rise.
    logic                                    r_armed;

    logic                                    w_rise;
    logic [POSITION_LEN-1:0]                 w_next_slot;

    assign w_rise = sort_valid & ~r_sort_valid_d & r_armed;

`ifdef PROJ_STREAMER_DESCENDING_EN
    assign w_next_slot = r_cnt - 1'b1;
`else
    assign w_next_slot = r_cnt + 1'b1;
`endif

    // Edge detect, snapshot buffer, slot counter and streaming FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_buf          <= '0;
            r_cnt          <= '0;
            r_out_index    <= '0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_out_done     <= 1'b0;
            r_overrun      <= 1'b0;
            r_sort_valid_d <= 1'b0;
            r_armed        <= 1'b0;
        end else begin
            r_sort_valid_d <= sort_valid;
            if (!sort_valid) begin
                r_armed <= 1'b1;
            end
            r_out_done <= 1'b0;
            if (w_rise && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_buf       <= in_smallest_idx;
                        r_cnt       <= FIRST_SLOT;
                        r_out_index <= in_smallest_idx[FIRST_SLOT];
                        r_out_valid <= 1'b1;
                        r_out_last  <= (FIRST_SLOT == LAST_SLOT);
                        r_state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (r_cnt == LAST_SLOT) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_done  <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            // Counter stops at the last slot; never wraps.
                            r_cnt       <= w_next_slot;
                            r_out_index <= r_buf[w_next_slot];
                            r_out_last  <= (w_next_slot == LAST_SLOT);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_index    = r_out_index;
    assign out_position = r_cnt;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign out_done     = r_out_done;
    assign busy         = (r_state != IDLE);
    assign overrun_err  = r_overrun;

endmodule
